// File: rtl/dllp_pkg.sv
// rtl/dllp_pkg.sv - shared data link layer types, LCRC constants and byte-wise LCRC step
package dllp_pkg;

  // LCRC generator polynomial (normal form) and its bit-reflected form used by the LSB-first engine
  localparam logic [31:0] LCRC_POLY      = 32'h04C11DB7;
  localparam logic [31:0] LCRC_POLY_REFL = 32'hEDB88320;
  localparam logic [31:0] LCRC_SEED      = 32'hFFFFFFFF;

  // Ack/Nak encoding shared with the transmit side
  localparam logic ACK = 1'b1;
  localparam logic NAK = 1'b0;

  typedef logic [11:0] seq_num_t;

  typedef enum logic [1:0] {IDLE, FWD, DROP} dllp_rx_state_e;

  // One byte of LCRC, bit 0 of the byte first; the register holds the reflected remainder
  function automatic logic [31:0] lcrc_byte(input logic [31:0] crc, input logic [7:0] b);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      c = (c[0] ^ b[i]) ? ((c >> 1) ^ LCRC_POLY_REFL) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/dllp_receive_if.sv
// rtl/dllp_receive_if.sv - phy/TLP streams and Ack/Nak request bundle for dllp_receive
interface dllp_receive_if
  import dllp_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int USER_WIDTH = 4
) ();

  logic [DATA_WIDTH-1:0] s_axis_phy_tdata_i;
  logic [KEEP_WIDTH-1:0] s_axis_phy_tkeep_i;
  logic                  s_axis_phy_tvalid_i;
  logic                  s_axis_phy_tlast_i;
  logic [USER_WIDTH-1:0] s_axis_phy_tuser_i;
  logic                  s_axis_phy_tready_o;

  logic [DATA_WIDTH-1:0] m_axis_tlp_tdata_o;
  logic [KEEP_WIDTH-1:0] m_axis_tlp_tkeep_o;
  logic                  m_axis_tlp_tvalid_o;
  logic                  m_axis_tlp_tlast_o;
  logic [USER_WIDTH-1:0] m_axis_tlp_tuser_o;
  logic                  m_axis_tlp_tready_i;

  logic                  ack_nack_o;
  logic                  ack_nack_vld_o;
  seq_num_t              ack_seq_num_o;
  seq_num_t              next_rcv_seq_o;

  // Receiver side
  modport slave (
    input  s_axis_phy_tdata_i, s_axis_phy_tkeep_i, s_axis_phy_tvalid_i,
    input  s_axis_phy_tlast_i, s_axis_phy_tuser_i, m_axis_tlp_tready_i,
    output s_axis_phy_tready_o, m_axis_tlp_tdata_o, m_axis_tlp_tkeep_o,
    output m_axis_tlp_tvalid_o, m_axis_tlp_tlast_o, m_axis_tlp_tuser_o,
    output ack_nack_o, ack_nack_vld_o, ack_seq_num_o, next_rcv_seq_o
  );

  // Phy / transaction layer side
  modport master (
    output s_axis_phy_tdata_i, s_axis_phy_tkeep_i, s_axis_phy_tvalid_i,
    output s_axis_phy_tlast_i, s_axis_phy_tuser_i, m_axis_tlp_tready_i,
    input  s_axis_phy_tready_o, m_axis_tlp_tdata_o, m_axis_tlp_tkeep_o,
    input  m_axis_tlp_tvalid_o, m_axis_tlp_tlast_o, m_axis_tlp_tuser_o,
    input  ack_nack_o, ack_nack_vld_o, ack_seq_num_o, next_rcv_seq_o
  );

endinterface

// File: rtl/dllp_rx_lcrc32.sv
// rtl/dllp_rx_lcrc32.sv - per-beat LCRC accumulator with byte enables and seed-on-first-beat
module dllp_rx_lcrc32
  import dllp_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_seed,
  input  logic        i_en,
  input  logic [31:0] i_data,
  input  logic [3:0]  i_keep,
  output logic [31:0] o_lcrc
);

  logic [31:0] r_crc;
  logic [31:0] w_next;

  // Fold the enabled bytes (byte 0 first) into either the seed or the running remainder
  always_comb begin
    w_next = i_seed ? LCRC_SEED : r_crc;
    for (int b = 0; b < 4; b++) begin
      if (i_keep[b]) w_next = lcrc_byte(w_next, i_data[8*b +: 8]);
    end
  end

  // Remainder register advances only on beats that belong to the covered byte stream
  always_ff @(posedge i_clk) begin
    if (i_rst) r_crc <= LCRC_SEED;
    else if (i_seed || i_en) r_crc <= w_next;
  end

  // Complemented reflected remainder; byte 0 of the LCRC dword sits in bits [7:0]
  assign o_lcrc = ~r_crc;

endmodule

// File: rtl/dllp_receive.sv
// rtl/dllp_receive.sv - receive data link layer: seq/LCRC check, cut-through TLP forward, Ack/Nak requests
module dllp_receive
  import dllp_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int USER_WIDTH = 4
) (
  input logic          clk_i,
  input logic          rst_i,
  dllp_receive_if.slave bus
);

  if (DATA_WIDTH != 32) begin : g_width_check
    $error("dllp_receive: DATA_WIDTH must be 32");
  end

  dllp_rx_state_e r_state;
  seq_num_t       r_next_rcv_seq;
  logic           r_nak_sched;
  logic           r_dup;
  logic           r_err;
  logic [1:0]     r_cnt;
  logic [31:0]    r_hold;
  logic           r_hold_vld;
  logic [31:0]    r_m_tdata;
  logic           r_m_tvalid;
  logic           r_m_tlast;
  logic           r_m_tuser0;
  logic           r_ack_nack;
  logic           r_ack_vld;

  logic [31:0] w_data;
  logic [31:0] w_lcrc;
  seq_num_t    w_seq_in;
  seq_num_t    w_seq_diff;
  logic        w_tready;
  logic        w_phy_fire;
  logic        w_out_fire;
  logic        w_err_any;
  logic        w_end_bad;
  logic        w_pkt_end;
  logic        w_good;
  logic        w_dup_ok;
  logic        w_unused_tuser;

  assign w_data     = bus.s_axis_phy_tdata_i[31:0];
  assign w_seq_in   = {w_data[3:0], w_data[15:8]};
  assign w_seq_diff = r_next_rcv_seq - 12'd1 - w_seq_in;

  // Only stall the phy while forwarding and the output register is occupied and blocked
  assign w_tready   = !rst_i && ((r_state != FWD) || !r_m_tvalid || bus.m_axis_tlp_tready_i);
  assign w_phy_fire = bus.s_axis_phy_tvalid_i && w_tready;
  assign w_out_fire = r_m_tvalid && bus.m_axis_tlp_tready_i;

  assign w_err_any  = r_err || bus.s_axis_phy_tuser_i[0];
  assign w_end_bad  = (w_data != w_lcrc) || w_err_any || (r_cnt != 2'd3);
  assign w_pkt_end  = w_phy_fire && bus.s_axis_phy_tlast_i;
  assign w_good     = (r_state == FWD) && !w_end_bad;
  assign w_dup_ok   = (r_state == DROP) && r_dup && !w_end_bad;
  assign w_unused_tuser = ^bus.s_axis_phy_tuser_i[USER_WIDTH-1:1];

  dllp_rx_lcrc32 u_lcrc (
    .i_clk  (clk_i),
    .i_rst  (rst_i),
    .i_seed (w_phy_fire && (r_state == IDLE)),
    .i_en   (w_phy_fire && (r_state != IDLE) && !bus.s_axis_phy_tlast_i),
    .i_data (w_data),
    .i_keep (bus.s_axis_phy_tkeep_i[3:0]),
    .o_lcrc (w_lcrc)
  );

  // Framing FSM, one-dword holdback for the LCRC beat, and Ack/Nak scheduling
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state        <= IDLE;
      r_next_rcv_seq <= '0;
      r_nak_sched    <= 1'b0;
      r_dup          <= 1'b0;
      r_err          <= 1'b0;
      r_cnt          <= '0;
      r_hold         <= '0;
      r_hold_vld     <= 1'b0;
      r_m_tdata      <= '0;
      r_m_tvalid     <= 1'b0;
      r_m_tlast      <= 1'b0;
      r_m_tuser0     <= 1'b0;
      r_ack_nack     <= 1'b0;
      r_ack_vld      <= 1'b0;
    end else begin
      if (w_out_fire) r_m_tvalid <= 1'b0;

      case (r_state)
        IDLE: begin
          if (w_phy_fire) begin
            r_cnt      <= '0;
            r_err      <= bus.s_axis_phy_tuser_i[0];
            r_hold_vld <= 1'b0;
            r_dup      <= !w_seq_diff[11];
            if (!bus.s_axis_phy_tlast_i)
              r_state <= (w_seq_in == r_next_rcv_seq) ? FWD : DROP;
          end
        end
        FWD: begin
          if (w_phy_fire) begin
            r_err <= w_err_any;
            if (r_hold_vld) begin
              r_m_tvalid <= 1'b1;
              r_m_tdata  <= r_hold;
              r_m_tlast  <= bus.s_axis_phy_tlast_i;
              r_m_tuser0 <= bus.s_axis_phy_tlast_i && w_end_bad;
            end
            if (bus.s_axis_phy_tlast_i) begin
              r_state    <= IDLE;
              r_hold_vld <= 1'b0;
            end else begin
              r_hold     <= w_data;
              r_hold_vld <= 1'b1;
              if (r_cnt != 2'd3) r_cnt <= r_cnt + 2'd1;
            end
          end
        end
        DROP: begin
          if (w_phy_fire) begin
            r_err <= w_err_any;
            if (bus.s_axis_phy_tlast_i) r_state <= IDLE;
            else if (r_cnt != 2'd3) r_cnt <= r_cnt + 2'd1;
          end
        end
        default: r_state <= IDLE;
      endcase

      r_ack_vld <= 1'b0;
      if (w_pkt_end) begin
        if (w_good) begin
          r_next_rcv_seq <= r_next_rcv_seq + 12'd1;
          r_nak_sched    <= 1'b0;
          r_ack_vld      <= 1'b1;
          r_ack_nack     <= ACK;
        end else if (w_dup_ok) begin
          r_ack_vld  <= 1'b1;
          r_ack_nack <= ACK;
        end else if (!r_nak_sched) begin
          r_ack_vld   <= 1'b1;
          r_ack_nack  <= NAK;
          r_nak_sched <= 1'b1;
        end
      end
    end
  end

  assign bus.s_axis_phy_tready_o = w_tready;
  assign bus.m_axis_tlp_tdata_o  = r_m_tdata;
  assign bus.m_axis_tlp_tkeep_o  = {KEEP_WIDTH{r_m_tvalid}};
  assign bus.m_axis_tlp_tvalid_o = r_m_tvalid;
  assign bus.m_axis_tlp_tlast_o  = r_m_tvalid && r_m_tlast;
  assign bus.m_axis_tlp_tuser_o  = {{(USER_WIDTH-1){1'b0}}, r_m_tvalid && r_m_tuser0};
  assign bus.ack_nack_o          = r_ack_nack;
  assign bus.ack_nack_vld_o      = r_ack_vld;
  assign bus.ack_seq_num_o       = r_next_rcv_seq - 12'd1;
  assign bus.next_rcv_seq_o      = r_next_rcv_seq;

endmodule

// File: tb/tb_dllp_receive.sv
// tb/tb_dllp_receive.sv - directed self-checking bench for dllp_receive
module tb_dllp_receive;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dllp_receive_if #(.DATA_WIDTH(32), .KEEP_WIDTH(4), .USER_WIDTH(4)) bus ();

  dllp_receive #(.DATA_WIDTH(32), .KEEP_WIDTH(4), .USER_WIDTH(4)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int          n_cmp = 0;
  int          n_err = 0;
  logic        toggle = 1'b0;
  logic [31:0] out_q[$];
  logic        out_last_q[$];
  logic        out_user_q[$];
  logic [12:0] ack_q[$];
  int          n_last = 0;
  logic        saw_stall = 1'b0;

  // Output beat / strobe collector, sampled mid-cycle
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.m_axis_tlp_tvalid_o && bus.m_axis_tlp_tready_i) begin
        out_q.push_back(bus.m_axis_tlp_tdata_o);
        out_last_q.push_back(bus.m_axis_tlp_tlast_o);
        out_user_q.push_back(bus.m_axis_tlp_tuser_o[0]);
        if (bus.m_axis_tlp_tlast_o) n_last++;
      end
      if (bus.ack_nack_vld_o) ack_q.push_back({bus.ack_nack_o, bus.ack_seq_num_o});
      if (bus.s_axis_phy_tvalid_i && !bus.s_axis_phy_tready_o) saw_stall = 1'b1;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] rev8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7-i];
    return r;
  endfunction

  function automatic logic [31:0] rev32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

  // MSB-first CRC-32 with reflected input bytes
  function automatic logic [31:0] crc_msb_byte(input logic [31:0] c_in, input logic [7:0] b);
    logic [31:0] c;
    c = c_in ^ {rev8(b), 24'h0};
    for (int i = 0; i < 8; i++) c = c[31] ? ((c << 1) ^ 32'h04C11DB7) : (c << 1);
    return c;
  endfunction

  function automatic logic [31:0] model_lcrc(input logic [11:0] seq, input logic [31:0] base, input int n);
    logic [31:0] c;
    logic [31:0] d;
    c = 32'hFFFFFFFF;
    c = crc_msb_byte(c, {4'h0, seq[11:8]});
    c = crc_msb_byte(c, seq[7:0]);
    for (int i = 0; i < n; i++) begin
      d = base + 32'(i);
      for (int k = 0; k < 4; k++) c = crc_msb_byte(c, d[8*k +: 8]);
    end
    return ~rev32(c);
  endfunction

  task automatic tick();
    @(posedge clk); #1;
    if (toggle) bus.m_axis_tlp_tready_i = ~bus.m_axis_tlp_tready_i;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
    logic acc;
    acc = 1'b0;
    bus.s_axis_phy_tdata_i  = d;
    bus.s_axis_phy_tkeep_i  = k;
    bus.s_axis_phy_tlast_i  = l;
    bus.s_axis_phy_tvalid_i = 1'b1;
    for (int g = 0; g < 50 && !acc; g++) begin
      @(negedge clk);
      acc = bus.s_axis_phy_tready_o;
      tick();
    end
    if (!acc) chk("beat_accept", {31'h0, acc}, 32'h1);
  endtask

  task automatic send_pkt(input logic [11:0] seq, input int n, input logic [31:0] base,
                          input logic [31:0] crc_xor, input logic hdr_only);
    logic [31:0] crc;
    crc = model_lcrc(seq, base, n) ^ crc_xor;
    send_beat({16'h0, seq[7:0], 4'h0, seq[11:8]}, 4'b0011, hdr_only);
    if (!hdr_only) begin
      for (int i = 0; i < n; i++) send_beat(base + 32'(i), 4'hF, 1'b0);
      send_beat(crc, 4'hF, 1'b1);
    end
    bus.s_axis_phy_tvalid_i = 1'b0;
    bus.s_axis_phy_tlast_i  = 1'b0;
  endtask

  task automatic clear();
    out_q.delete(); out_last_q.delete(); out_user_q.delete(); ack_q.delete();
  endtask

  task automatic check_out(input string tag, input logic [31:0] base, input int n, input logic user);
    chk({tag, "_nbeats"}, out_q.size(), n);
    for (int i = 0; i < n && i < out_q.size(); i++) begin
      chk({tag, "_data"}, out_q[i], base + 32'(i));
      chk({tag, "_last"}, {31'h0, out_last_q[i]}, {31'h0, (i == n - 1)});
      chk({tag, "_user"}, {31'h0, out_user_q[i]}, {31'h0, (i == n - 1) && user});
    end
  endtask

  task automatic check_ack(input string tag, input logic nack, input logic [11:0] seq);
    chk({tag, "_nstrobe"}, ack_q.size(), 1);
    if (ack_q.size() >= 1) chk({tag, "_acknak"}, {19'h0, ack_q[0]}, {19'h0, nack, seq});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.s_axis_phy_tvalid_i = 1'b0;
    idle(3);
    rst = 1'b0;
    idle(1);
  endtask

  initial begin
    rst = 1'b1;
    bus.s_axis_phy_tdata_i  = '0;
    bus.s_axis_phy_tkeep_i  = '0;
    bus.s_axis_phy_tvalid_i = 1'b0;
    bus.s_axis_phy_tlast_i  = 1'b0;
    bus.s_axis_phy_tuser_i  = '0;
    bus.m_axis_tlp_tready_i = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tready",   {31'h0, bus.s_axis_phy_tready_o}, 32'h0);
    chk("rst_tvalid",   {31'h0, bus.m_axis_tlp_tvalid_o}, 32'h0);
    chk("rst_tdata",    bus.m_axis_tlp_tdata_o, 32'h0);
    chk("rst_tkeep",    {28'h0, bus.m_axis_tlp_tkeep_o}, 32'h0);
    chk("rst_ackvld",   {31'h0, bus.ack_nack_vld_o}, 32'h0);
    chk("rst_acknak",   {31'h0, bus.ack_nack_o}, 32'h0);
    chk("rst_ackseq",   {20'h0, bus.ack_seq_num_o}, 32'hFFF);
    chk("rst_nextseq",  {20'h0, bus.next_rcv_seq_o}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_tready", {31'h0, bus.s_axis_phy_tready_o}, 32'h1);
    @(posedge clk); #1;

    // Good TLP seq 0
    clear();
    send_pkt(12'd0, 3, 32'hA0A1A2A0, 32'h0, 1'b0);
    idle(4);
    check_out("good0", 32'hA0A1A2A0, 3, 1'b0);
    check_ack("good0", 1'b1, 12'h000);
    chk("good0_next", {20'h0, bus.next_rcv_seq_o}, 32'h1);

    // Bad LCRC after reset, second bad silent, then good
    do_reset();
    clear();
    send_pkt(12'd0, 3, 32'h11223340, 32'h1, 1'b0);
    idle(4);
    check_out("badcrc", 32'h11223340, 3, 1'b1);
    check_ack("badcrc", 1'b0, 12'hFFF);
    clear();
    send_pkt(12'd0, 3, 32'h55667780, 32'h1, 1'b0);
    idle(4);
    chk("badcrc2_nstrobe", ack_q.size(), 0);
    clear();
    send_pkt(12'd0, 3, 32'h9ABCDEF0, 32'h0, 1'b0);
    idle(4);
    check_ack("recover", 1'b1, 12'h000);

    // Advance to NEXT_RCV_SEQ=5, then duplicate and future sequence numbers
    for (int s = 1; s <= 4; s++) send_pkt(12'(s), 3, 32'h01000000 * s, 32'h0, 1'b0);
    idle(4);
    chk("adv_next", {20'h0, bus.next_rcv_seq_o}, 32'h5);
    clear();
    send_pkt(12'd3, 3, 32'hDDDD0000, 32'h0, 1'b0);
    idle(4);
    chk("dup_nbeats", out_q.size(), 0);
    check_ack("dup", 1'b1, 12'd4);
    chk("dup_next", {20'h0, bus.next_rcv_seq_o}, 32'h5);
    clear();
    send_pkt(12'd9, 3, 32'hEEEE0000, 32'h0, 1'b0);
    idle(4);
    chk("future_nbeats", out_q.size(), 0);
    check_ack("future", 1'b0, 12'd4);
    chk("future_next", {20'h0, bus.next_rcv_seq_o}, 32'h5);

    // Walk up to 4095 and wrap
    for (int s = 5; s <= 4094; s++) send_pkt(12'(s), 3, 32'h00010000 + 32'(s), 32'h0, 1'b0);
    idle(4);
    chk("walk_next", {20'h0, bus.next_rcv_seq_o}, 32'hFFF);
    clear();
    send_pkt(12'hFFF, 3, 32'hCAFE0000, 32'h0, 1'b0);
    send_pkt(12'h000, 3, 32'hBEEF0000, 32'h0, 1'b0);
    idle(4);
    chk("wrap_nstrobe", ack_q.size(), 2);
    if (ack_q.size() == 2) begin
      chk("wrap_ack4095", {19'h0, ack_q[0]}, {19'h0, 1'b1, 12'hFFF});
      chk("wrap_ack0",    {19'h0, ack_q[1]}, {19'h0, 1'b1, 12'h000});
    end
    chk("wrap_next", {20'h0, bus.next_rcv_seq_o}, 32'h1);

    // Output backpressure toggling every cycle on a 6-dword TLP
    clear();
    saw_stall = 1'b0;
    toggle = 1'b1;
    send_pkt(12'd1, 6, 32'h60000010, 32'h0, 1'b0);
    idle(10);
    toggle = 1'b0;
    bus.m_axis_tlp_tready_i = 1'b1;
    idle(1);
    check_out("bp", 32'h60000010, 6, 1'b0);
    chk("bp_stall_seen", {31'h0, saw_stall}, 32'h1);
    check_ack("bp", 1'b1, 12'd1);
    chk("bp_next", {20'h0, bus.next_rcv_seq_o}, 32'h2);

    // Header-only runt
    clear();
    send_pkt(12'd2, 0, 32'h0, 32'h0, 1'b1);
    idle(4);
    chk("runt_nbeats", out_q.size(), 0);
    check_ack("runt", 1'b0, 12'd1);

    // Reset in the middle of a TLP
    clear();
    begin
      int last_before;
      last_before = n_last;
      send_beat({16'h0, 8'h02, 8'h00}, 4'b0011, 1'b0);
      send_beat(32'h77770000, 4'hF, 1'b0);
      send_beat(32'h77770001, 4'hF, 1'b0);
      rst = 1'b1;
      tick();
      @(negedge clk);
      chk("midrst_tready", {31'h0, bus.s_axis_phy_tready_o}, 32'h0);
      chk("midrst_tvalid", {31'h0, bus.m_axis_tlp_tvalid_o}, 32'h0);
      chk("midrst_tlast",  {31'h0, bus.m_axis_tlp_tlast_o}, 32'h0);
      chk("midrst_ackvld", {31'h0, bus.ack_nack_vld_o}, 32'h0);
      chk("midrst_ackseq", {20'h0, bus.ack_seq_num_o}, 32'hFFF);
      chk("midrst_next",   {20'h0, bus.next_rcv_seq_o}, 32'h0);
      @(posedge clk); #1;
      bus.s_axis_phy_tvalid_i = 1'b0;
      rst = 1'b0;
      idle(4);
      chk("midrst_nstrobe", ack_q.size(), 0);
      chk("midrst_ntlast", n_last - last_before, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
